// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the 3-bit ALU scheduler: op codes, FSM encoding,
// operand width and the latched request payload.
package alu_sched_pkg;

    localparam int unsigned OPW  = 3;
    localparam int unsigned CNTW = 8;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_MUL   = 3'd2,
        OP_DIV   = 3'd3,
        OP_SHL   = 3'd4,
        OP_SHR   = 3'd5,
        OP_RSVD6 = 3'd6,
        OP_RSVD7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic           id;
        op_e            op;
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
    } req_t;

    // Ops whose result must not come from the ALU.
    function automatic logic op_is_err(input op_e op, input logic [OPW-1:0] b);
        return (op == OP_RSVD6) || (op == OP_RSVD7) || ((op == OP_DIV) && (b == '0));
    endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between two requesters, the scheduler and its consumer.
interface alu_sched_if;
    import alu_sched_pkg::*;

    logic                req0_valid;
    logic                req0_ready;
    logic [OPW-1:0]      req0_a;
    logic [OPW-1:0]      req0_b;
    logic [OPW-1:0]      req0_op;
    logic                req1_valid;
    logic                req1_ready;
    logic [OPW-1:0]      req1_a;
    logic [OPW-1:0]      req1_b;
    logic [OPW-1:0]      req1_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [OPW-1:0]      rsp_result;
    logic                rsp_carry;
    logic                rsp_err;
    logic                busy;
    logic [CNTW-1:0]     ops_done;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, busy, ops_done
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, busy, ops_done
    );

endinterface

// File: rtl/alu_sched_alu.sv
// Shared 3-bit combinational ALU; carry reports bit 3 of the 4-bit sum and only for ADD.
module alu_sched_alu
    import alu_sched_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  op_e            op,
    output logic [OPW-1:0] result,
    output logic           carry
);

    logic [OPW:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[OPW-1:0];
                carry  = sum[OPW];
            end
            OP_SUB:  result = a - b;
            OP_MUL:  result = OPW'(a * b);
            OP_DIV:  result = (b == '0) ? '0 : a / b;
            OP_SHL:  result = {a[OPW-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[OPW-1:1]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_sched_arb.sv
// Stateless two-way arbiter: round-robin against last_id or fixed priority to requester 0.
module alu_sched_arb #(
    parameter bit FAIR_RR = 1'b1
) (
    input  logic valid0,
    input  logic valid1,
    input  logic last_id,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = 1'b0;
        if (valid0 && valid1) begin
            grant_id = FAIR_RR ? ~last_id : 1'b0;
        end else if (valid1) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Schedules operations from two requesters onto one shared ALU: IDLE accepts, EXEC
// registers the ALU result, RESP holds the response until the consumer takes it.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter bit FAIR_RR = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    alu_sched_if.slave bus
);

    state_e          state;
    req_t            lat;
    logic            last_id;
    logic            rsp_id_q;
    logic [OPW-1:0]  rsp_result_q;
    logic            rsp_carry_q;
    logic            rsp_err_q;
    logic [CNTW-1:0] ops_done_q;

    logic            grant_valid;
    logic            grant_id;
    logic            idle_c;
    logic            ready0_c;
    logic            ready1_c;
    logic [OPW-1:0]  alu_result;
    logic            alu_carry;

    alu_sched_arb #(.FAIR_RR(FAIR_RR)) u_arb (
        .valid0      (bus.req0_valid),
        .valid1      (bus.req1_valid),
        .last_id     (last_id),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    alu_sched_alu u_alu (
        .a      (lat.a),
        .b      (lat.b),
        .op     (lat.op),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Grant is only offered while idle and never during a reset cycle.
    assign idle_c   = (state == ST_IDLE) && !reset;
    assign ready0_c = idle_c && grant_valid && !grant_id && bus.req0_valid;
    assign ready1_c = idle_c && grant_valid &&  grant_id && bus.req1_valid;

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.ops_done   = ops_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            lat          <= '0;
            last_id      <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ready1_c) begin
                        lat     <= '{id: 1'b1, op: op_e'(bus.req1_op), a: bus.req1_a, b: bus.req1_b};
                        last_id <= 1'b1;
                        state   <= ST_EXEC;
                    end else if (ready0_c) begin
                        lat     <= '{id: 1'b0, op: op_e'(bus.req0_op), a: bus.req0_a, b: bus.req0_b};
                        last_id <= 1'b0;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_id_q <= lat.id;
                    if (op_is_err(lat.op, lat.b)) begin
                        rsp_result_q <= '0;
                        rsp_carry_q  <= 1'b0;
                        rsp_err_q    <= 1'b1;
                    end else begin
                        rsp_result_q <= alu_result;
                        rsp_carry_q  <= alu_carry;
                        rsp_err_q    <= 1'b0;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        ops_done_q <= ops_done_q + CNTW'(1);
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter FAIR_RR, default 1, 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1 each  requester has an operation pending.
REQ-005 req0_ready / req1_ready  out  1 each  scheduler accepts that requester's operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  3 each  operands.
REQ-007 req0_op / req1_op  in  3 each  operation select: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL (A), 5 SHR (A), 6-7 reserved.
REQ-008 rsp_valid  out  1  response available.
REQ-009 rsp_ready  in  1  consumer accepts the response.
REQ-010 rsp_id  out  1  index of the requester that issued the operation.
REQ-011 rsp_result  out  3  operation result, truncated to 3 bits.
REQ-012 rsp_carry  out  1  carry out of the 4-bit sum A+B; valid for ADD only, 0 for all other ops.
REQ-013 rsp_err  out  1  1 = reserved op or DIV with B = 0.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 ops_done  out  8  count of completed response handshakes.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-017 In IDLE, the grant SHALL be computed combinationally from the valid inputs: only one valid -> that requester; both valid -> FAIR_RR=1 grants the requester not equal to last_id, FAIR_RR=0 grants requester 0.
REQ-018 reqN_ready SHALL be 1 only in IDLE, only for the granted requester, and only while reqN_valid=1; never both ready in the same cycle.
REQ-019 On accept (reqN_valid & reqN_ready), the scheduler SHALL latch a, b, op and id, set last_id = N, and move IDLE -> EXEC.
REQ-020 In EXEC, the scheduler SHALL drive the latched operands into the ALU instance, register result, carry and err into the response registers, and move EXEC -> RESP.
REQ-021 In RESP, rsp_valid SHALL be 1, and the rsp_* outputs SHALL be held stable until rsp_ready=1.
REQ-022 On a response handshake, the scheduler SHALL go RESP -> IDLE and increment ops_done (wrapping 255 -> 0).
REQ-023 Latency: accept at cycle N -> rsp_valid at cycle N+2; minimum issue interval 3 cycles.
REQ-024 For DIV with B=0, and for op 6 or 7, the scheduler SHALL set rsp_err=1, rsp_result=0 and rsp_carry=0, and SHALL NOT use the ALU output.
REQ-025 SUB SHALL wrap modulo 8, and MUL SHALL keep the low 3 bits of the product.
REQ-026 Valids that change while the scheduler is not in IDLE SHALL be ignored, and requesters SHALL hold valid and operands stable until accepted.

Reset
REQ-027 On reset=1 at a clock edge, the scheduler SHALL enter IDLE and set rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_err=0, ops_done=0, last_id=1 (requester 0 wins the first tie), busy=0, and both ready=0 during that cycle.
REQ-028 A reset asserted during EXEC or RESP SHALL abort the operation, and the pending response SHALL be discarded without incrementing ops_done.

Structure
REQ-029 A shared package alu_sched_pkg SHALL hold the op-code constants (OP_ADD..OP_SHR, OP_RSVD6/7), the FSM state encoding, and the operand width constant (3).
REQ-030 The datapath SHALL be the team's existing 3-bit ALU module, instantiated once; the scheduler SHALL NOT duplicate its arithmetic.
REQ-031 Arbitration SHALL live in one sub-module, alu_sched_arb (valids, last_id, FAIR_RR -> grant), with no state of its own.

Verification
REQ-032 Scenario: after reset, req0 ADD a=5 b=6 with rsp_ready=1 -> req0_ready in the same cycle, rsp_valid 2 cycles later, result 3, carry 1, err 0, id 0, ops_done=1.
REQ-033 Scenario: req0 and req1 both valid continuously, FAIR_RR=1 -> grants alternate 0,1,0,1 over 4 operations; with FAIR_RR=0 -> requester 0 always wins.
REQ-034 Scenario: DIV a=7 b=0 -> err 1, result 0; DIV a=7 b=2 -> result 3, err 0; op 6 -> err 1, result 0.
REQ-035 Scenario: rsp_ready held low for 5 cycles in RESP -> rsp_* outputs stable, no new accept, busy=1; release -> IDLE on the next cycle.
REQ-036 Scenario: reset pulsed during EXEC -> outputs at reset values the next cycle, ops_done unchanged at 0, and the next tie is granted to req0.
REQ-037 Scenario: 256 back-to-back operations -> ops_done wraps to 0; SUB a=1 b=2 -> result 7; MUL a=3 b=3 -> result 1.
